// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the write-side arbiter signals: the source A writeback, the
// source B result stream, the issue/scoreboard hooks and the register-file
// write port. The master modport is the environment; the slave is the
// arbiter.
interface regfile_wb_arbiter_if;

    // Source A: in-order pipeline writeback, never back-pressured
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;

    // Source B: long-latency results, queued in the arbiter FIFO
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;

    // Issue of an instruction whose result will come back on source B
    logic        iss_valid;
    logic [4:0]  iss_addr;

    // Scoreboard queries
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        q_busy1;
    logic        q_busy2;

    // Register-file write port and protocol flag
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        err;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output iss_valid, iss_addr,
        output q_addr1, q_addr2,
        input  b_ready,
        input  q_busy1, q_busy2,
        input  we3, wa3, wd3,
        input  err
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  iss_valid, iss_addr,
        input  q_addr1, q_addr2,
        output b_ready,
        output q_busy1, q_busy2,
        output we3, wa3, wd3,
        output err
    );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-side front end of the three-ported register file. Source A (the
// in-order writeback) always has priority on the single write port; source B
// results wait in a small FIFO and drain on cycles where A is idle. A
// per-register pending scoreboard tracks destinations still owed a source B
// result, and a sticky flag records protocol violations.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    regfile_wb_arbiter_if.slave  wb
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]       fifo_addr_mem [DEPTH];
    logic [31:0]      fifo_data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic [31:0]      pend_q,   pend_d;

    logic             we3_q,    we3_d;
    logic [4:0]       wa3_q,    wa3_d;
    logic [31:0]      wd3_q,    wd3_d;
    logic             err_q,    err_d;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic             fifo_empty;
    logic             b_ready_w;
    logic             push;
    logic             pop;
    logic [4:0]       head_addr;
    logic [31:0]      head_data;

    // Ready is a function of the registered occupancy only, so it never
    // depends on what source A is doing this cycle.
    assign fifo_empty = (count_q == '0);
    assign b_ready_w  = (count_q != FULL_CNT);
    assign push       = wb.b_valid & b_ready_w;

    // Source A owns the port whenever it is valid; the FIFO only drains on
    // A-idle cycles and is never bypassed, even when it is empty.
    assign pop        = ~wb.a_valid & ~fifo_empty;

    assign head_addr  = fifo_addr_mem[rd_ptr_q];
    assign head_data  = fifo_data_mem[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO payload storage; contents need no reset because occupancy
    // decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= wb.b_addr;
            fifo_data_mem[wr_ptr_q] <= wb.b_data;
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard
    // ------------------------------------------------------------------
    // r0 is hard-wired to zero, so it can never be owed a result.
    assign pend_d[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_pend
            logic set_w;
            logic clr_w;
            assign set_w = wb.iss_valid & (wb.iss_addr == 5'(gi));
            assign clr_w = pop & (head_addr == 5'(gi));
            // A new issue and the retiring result for the same register in
            // the same cycle leave the bit set: the new issue still owes one.
            assign pend_d[gi] = set_w | (pend_q[gi] & ~clr_w);
        end
    endgenerate

    assign wb.q_busy1 = pend_q[wb.q_addr1];
    assign wb.q_busy2 = pend_q[wb.q_addr2];

    // ------------------------------------------------------------------
    // Protocol checking
    // ------------------------------------------------------------------
    logic waw_err;
    logic a_err;
    logic b_err;

    // Violations are flagged but never block the offending operation. An
    // issue to a register whose result retires in this very cycle is not a
    // WAW hazard, since the older result is leaving the scoreboard.
    always_comb begin
        waw_err = wb.iss_valid & pend_q[wb.iss_addr]
                & ~(pop & (head_addr == wb.iss_addr));
        a_err   = wb.a_valid & (wb.a_addr != 5'd0) & pend_q[wb.a_addr];
        b_err   = push & (wb.b_addr != 5'd0) & ~pend_q[wb.b_addr];
        err_d   = err_q | waw_err | a_err | b_err;
    end

    // ------------------------------------------------------------------
    // Write-port selection
    // ------------------------------------------------------------------
    // Pick this cycle's writer; with nothing to write the enable drops and
    // address/data keep their last values.
    always_comb begin
        we3_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (wb.a_valid) begin
            we3_d = (wb.a_addr != 5'd0);
            wa3_d = wb.a_addr;
            wd3_d = wb.a_data;
        end else if (!fifo_empty) begin
            we3_d = (head_addr != 5'd0);
            wa3_d = head_addr;
            wd3_d = head_data;
        end
    end

    // All control state, with asynchronous clear so nothing is written and
    // nothing stays queued once reset asserts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= 5'd0;
            wd3_q    <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
            err_q    <= err_d;
        end
    end

    assign wb.b_ready = b_ready_w;
    assign wb.we3     = we3_q;
    assign wb.wa3     = wa3_q;
    assign wb.wd3     = wd3_q;
    assign wb.err     = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random
// traffic, checked by a scoreboard fed from a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .wb     (bus)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } port_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    ent_t        fifo_m [$];
    port_t       exp_q  [$];
    port_t       port_m;
    logic [31:0] pend_m;
    logic        err_m;
    bit          last_push;
    int          issued [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Behavioural model of one clock edge, from the arbiter's rules.
    task automatic model_step();
        ent_t       h;
        bit         popped = 0;
        logic [4:0] pa = 5'd0;
        bit         push;
        push = bus.b_valid && (fifo_m.size() != DEPTH);
        if (bus.a_valid) begin
            port_m = '{(bus.a_addr != 0), bus.a_addr, bus.a_data};
        end else if (fifo_m.size() != 0) begin
            h = fifo_m.pop_front();
            popped = 1;
            pa = h.addr;
            port_m = '{(h.addr != 0), h.addr, h.data};
        end else begin
            port_m.we = 1'b0;
        end
        if (bus.iss_valid && pend_m[bus.iss_addr] && !(popped && pa == bus.iss_addr)) err_m = 1'b1;
        if (bus.a_valid && bus.a_addr != 0 && pend_m[bus.a_addr]) err_m = 1'b1;
        if (push && bus.b_addr != 0 && !pend_m[bus.b_addr]) err_m = 1'b1;
        if (popped) pend_m[pa] = 1'b0;
        if (bus.iss_valid && bus.iss_addr != 0) pend_m[bus.iss_addr] = 1'b1;
        if (push) fifo_m.push_back('{bus.b_addr, bus.b_data});
        exp_q.push_back(port_m);
        last_push = push;
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetn) model_step();
        #2;
    endtask

    task automatic set_idle();
        bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
        bus.iss_valid = 0; bus.iss_addr = 0;
    endtask

    task automatic drive(input bit av, input int aa, input logic [31:0] ad,
                         input bit bv, input int ba, input logic [31:0] bd,
                         input bit iv, input int ia);
        bus.a_valid = av; bus.a_addr = 5'(aa); bus.a_data = ad;
        bus.b_valid = bv; bus.b_addr = 5'(ba); bus.b_data = bd;
        bus.iss_valid = iv; bus.iss_addr = 5'(ia);
    endtask

    task automatic idle_ticks(input int n);
        set_idle();
        repeat (n) tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_idle();
        fifo_m.delete();
        exp_q.delete();
        issued.delete();
        pend_m = '0;
        err_m = 1'b0;
        port_m = '{1'b0, 5'd0, 32'd0};
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    // Monitor: one expected port state per clock edge, compared on the
    // opposite edge together with the registered-state outputs.
    always @(negedge clk) begin : monitor
        port_t e;
        if (!resetn) begin
            chk("reset_port", {bus.we3, bus.wa3, bus.wd3}, 38'd0);
            chk("reset_b_ready", 64'(bus.b_ready), 64'd1);
            chk("reset_err", 64'(bus.err), 64'd0);
            chk("reset_busy1", 64'(bus.q_busy1), 64'd0);
        end else begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = port_m;
            chk("port", {bus.we3, bus.wa3, bus.wd3}, {e.we, e.wa, e.wd});
            chk("b_ready", 64'(bus.b_ready), 64'(fifo_m.size() != DEPTH));
            chk("err", 64'(bus.err), 64'(err_m));
            chk("q_busy1", 64'(bus.q_busy1), 64'(pend_m[bus.q_addr1]));
            chk("q_busy2", 64'(bus.q_busy2), 64'(pend_m[bus.q_addr2]));
            if (bus.we3 === 1'b1)
                $display("WB t=%0t r%0d <= %h", $time, bus.wa3, bus.wd3);
        end
    end

    function automatic int pick_free();
        for (int k = 0; k < 64; k++) begin
            int x = $urandom_range(1, 31);
            if (!pend_m[x]) return x;
        end
        return 0;
    endfunction

    initial begin
        set_idle();
        bus.q_addr1 = 0;
        bus.q_addr2 = 0;
        do_reset();

        // Single source A write
        bus.q_addr1 = 5;
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        tick();
        idle_ticks(3);

        // Issue, later B result, scoreboard clears on pop
        bus.q_addr1 = 9;
        drive(0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        idle_ticks(3);
        drive(0, 0, 0, 1, 9, 32'h1234, 0, 0);
        tick();
        idle_ticks(4);

        // Fill the FIFO while A hogs the port, then let it drain
        bus.q_addr1 = 10;
        bus.q_addr2 = 13;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, $urandom, 0, 0, 0, 1, 10 + i);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 2, $urandom, 1, 10 + (i % 4), 32'hB000 + i, 0, 0);
            tick();
        end
        idle_ticks(7);

        // r0 from both sources
        drive(0, 0, 0, 1, 0, 32'h5555, 0, 0);
        tick();
        drive(1, 0, 32'h7777, 0, 0, 0, 1, 0);
        tick();
        idle_ticks(3);

        // Double issue of r3 sets err, which sticks
        bus.q_addr1 = 3;
        drive(0, 0, 0, 0, 0, 0, 1, 3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 3);
        tick();
        idle_ticks(3);
        do_reset();

        // A write to pending r7
        bus.q_addr1 = 7;
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        drive(1, 7, 32'hAAAA, 0, 0, 0, 0, 0);
        tick();
        idle_ticks(3);
        do_reset();

        // Re-issue of r4 in the cycle its result pops: set wins, no err
        bus.q_addr1 = 4;
        drive(0, 0, 0, 0, 0, 0, 1, 4);
        tick();
        idle_ticks(1);
        drive(0, 0, 0, 1, 4, 32'h4444, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 4);
        tick();
        idle_ticks(3);
        do_reset();

        // Random legal traffic with varying source A density
        for (int blk = 0; blk < 12; blk++) begin
            int dens = $urandom_range(0, 3);
            for (int c = 0; c < 50; c++) begin
                bit bv = 0;
                int ba = 0;
                bit iv = 0;
                int ia = 0;
                bit av = ($urandom_range(0, 3) < dens);
                int aa = av ? pick_free() : 0;
                if (issued.size() > 0 && $urandom_range(0, 1) == 1) begin
                    bv = 1;
                    ba = issued[0];
                end else if ($urandom_range(0, 7) == 0) begin
                    bv = 1;
                    ba = 0;
                end
                if (issued.size() < 6 && $urandom_range(0, 2) == 0) begin
                    ia = pick_free();
                    iv = (ia != 0);
                    if (iv && av && aa == ia) av = 0;
                end
                bus.q_addr1 = 5'($urandom_range(0, 31));
                bus.q_addr2 = (issued.size() > 0) ? 5'(issued[0]) : 5'($urandom_range(0, 31));
                drive(av, aa, $urandom, bv, ba, $urandom, iv, ia);
                tick();
                if (iv) issued.push_back(ia);
                if (bv && last_push && ba != 0) void'(issued.pop_front());
            end
        end
        idle_ticks(8);
        do_reset();

        // Unconstrained traffic including violations and a mid-run reset
        for (int c = 0; c < 300; c++) begin
            if (c == 150) do_reset();
            bus.q_addr1 = 5'($urandom_range(0, 7));
            bus.q_addr2 = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 7));
            tick();
        end
        idle_ticks(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side front end for the three-ported register file. Merges two result streams onto its single write port (we3/wa3/wd3):
  - the in-order pipeline writeback (source A);
  - a long-latency unit such as load or mul/div (source B), queued in a small FIFO.
- Keeps a per-register pending scoreboard so issue logic can stall on registers awaiting a source-B result.

Parameters:
- DEPTH, 4, source-B FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state changes on posedge.
- resetn  in  1  async active-low reset.
- a_valid  in  1  source A write request; always accepted, no backpressure.
- a_addr  in  5  source A destination register.
- a_data  in  32  source A write data.
- b_valid  in  1  source B result valid.
- b_ready  out  1  source B accept; transfer on b_valid & b_ready at posedge.
- b_addr  in  5  source B destination register.
- b_data  in  32  source B write data.
- iss_valid  in  1  an instruction targeting source B issues this cycle.
- iss_addr  in  5  its destination register.
- q_addr1  in  5  scoreboard query address 1.
- q_addr2  in  5  scoreboard query address 2.
- q_busy1  out  1  pend[q_addr1]; combinational from registered state.
- q_busy2  out  1  pend[q_addr2]; combinational from registered state.
- we3  out  1  register-file write enable (registered).
- wa3  out  5  register-file write address (registered).
- wd3  out  32  register-file write data (registered).
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (resetn low, asynchronous):
  - we3=0, wa3=0, wd3=0, err=0.
  - FIFO empty (read/write pointers 0, count 0), pend[31:0]=0.
  - b_ready=1 during and after reset.
- FIFO:
  - DEPTH entries of {addr, data}; count is DEPTH+1 range.
  - b_ready = (count != DEPTH); depends only on registered count, never on a_valid.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
- Write-port selection each cycle, registered to we3/wa3/wd3 at the next posedge:
  - a_valid=1: {we3,wa3,wd3} <= {a_addr!=0, a_addr, a_data}; FIFO does not pop.
  - else if FIFO not empty: pop head; {we3,wa3,wd3} <= {head.addr!=0, head.addr, head.data}.
  - else: we3 <= 0; wa3/wd3 hold their previous values.
- Latency:
  - Source A: a_valid at edge N-1..N gives we3=1 in cycle N+1 (one-register latency).
  - Source B: accepted at edge N, earliest we3 in cycle N+2.
  - FIFO is never bypassed.
- Register 0:
  - Writes to r0 from either source produce we3=0.
  - An r0 FIFO entry is still popped.
  - pend[0] is never set.
- Scoreboard:
  - iss_valid & iss_addr!=0 sets pend[iss_addr].
  - A source-B pop clears pend[head.addr].
  - Set and clear of the same address in the same cycle: set wins.
- err sets (sticky until reset) when any of these holds:
  - iss_valid to an address whose pend bit is already 1 (WAW on B);
  - a_valid with a_addr!=0 whose pend bit is 1;
  - b_valid & b_ready with b_addr!=0 whose pend bit is 0.
  - Violating operations still proceed as described above.
- Starvation: continuous a_valid blocks the FIFO indefinitely. Upstream relies on pend stalls to create A-idle cycles. No internal fairness counter.
- Reset mid-operation discards queued entries and pending bits; no writes are emitted after reset asserts.

Test Plan:
- Reset, then a_valid=1, a_addr=5, a_data=0xDEADBEEF for one cycle -> we3=1, wa3=5, wd3=0xDEADBEEF in the next cycle only; err=0.
- iss r9; 3 cycles later B pushes {9,0x1234} with A idle -> q_busy(9)=1 until pop; we3=1, wa3=9, wd3=0x1234 two cycles after accept; q_busy(9)=0 afterwards.
- a_valid held high while B pushes DEPTH entries -> b_ready=0 after 4th accept. Then drop a_valid -> 4 consecutive B writes in push order; b_ready returns 1 the cycle after first pop.
- B push to r0 (with r0 ignored by the scoreboard) and a_valid to r0 -> we3 stays 0 both cycles; FIFO count returns to 0.
- iss r3 twice -> err=1 and stays 1. Separately, a_valid to pending r7 -> err=1.
- Pop of r4 in the same cycle iss_valid to r4 -> pend[4] remains 1 (set wins); no err raised for the new issue.
